// File: rtl/xresponder_if.sv
// rtl/xresponder_if.sv - Versat burst handshake bus between the merge initiator and the responder
// Purpose: groups the write and read burst channels of the Versat handshake.
// Ports (signals):
//   write: m_wvalid_i, m_wready_o, m_waddr_i, m_wdata_i, m_wstrb_i, m_wlen_i, m_wlast_o
//   read : m_rvalid_i, m_rready_o, m_raddr_i, m_rdata_o, m_rlen_i, m_rlast_o
// Modports: master = initiator side, slave = responder side.
interface xresponder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic                  m_wvalid_i;
  logic                  m_wready_o;
  logic [ADDR_W-1:0]     m_waddr_i;
  logic [DATA_W-1:0]     m_wdata_i;
  logic [DATA_W/8-1:0]   m_wstrb_i;
  logic [LEN_W-1:0]      m_wlen_i;
  logic                  m_wlast_o;
  logic                  m_rvalid_i;
  logic                  m_rready_o;
  logic [ADDR_W-1:0]     m_raddr_i;
  logic [DATA_W-1:0]     m_rdata_o;
  logic [LEN_W-1:0]      m_rlen_i;
  logic                  m_rlast_o;

  modport master (
    output m_wvalid_i, m_waddr_i, m_wdata_i, m_wstrb_i, m_wlen_i,
    output m_rvalid_i, m_raddr_i, m_rlen_i,
    input  m_wready_o, m_wlast_o, m_rready_o, m_rdata_o, m_rlast_o
  );

  modport slave (
    input  m_wvalid_i, m_waddr_i, m_wdata_i, m_wstrb_i, m_wlen_i,
    input  m_rvalid_i, m_raddr_i, m_rlen_i,
    output m_wready_o, m_wlast_o, m_rready_o, m_rdata_o, m_rlast_o
  );
endinterface

// File: rtl/xresponder.sv
// rtl/xresponder.sv - Versat burst handshake responder driving word-addressed memory command ports
// Purpose: converts write/read bursts (addr+len per burst, responder-driven last)
//   into per-word memory write/read commands. Reads use a credit-limited prefetch
//   FIFO so any in-order memory latency is tolerated without overflow.
// Ports:
//   clk_i, rst_i (asynchronous, active-high)
//   m            : xresponder_if.slave burst bus
//   mem_wen_o/mem_wready_i/mem_waddr_o/mem_wdata_o/mem_wstrb_o : memory write command
//   mem_ren_o/mem_rready_i/mem_raddr_o : memory read command
//   mem_rvalid_i/mem_rdata_i           : in-order read data return
//   burst_cnt_o  : completed burst count (XRESPONDER_BURST_COUNT_EN), else 0
// Optional feature macro: XRESPONDER_BURST_COUNT_EN
module xresponder #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int LEN_W         = 8,
  parameter int RD_FIFO_DEPTH = 4,
  localparam int BYTE_W       = $clog2(DATA_W/8),
  localparam int WORD_W       = ADDR_W - BYTE_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  xresponder_if.slave         m,
  output logic                mem_wen_o,
  input  logic                mem_wready_i,
  output logic [WORD_W-1:0]   mem_waddr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic                mem_ren_o,
  input  logic                mem_rready_i,
  output logic [WORD_W-1:0]   mem_raddr_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [31:0]         burst_cnt_o
);
  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Byte offsets below the word boundary are ignored by design.
  logic unused_bits;
  assign unused_bits = ^{m.m_waddr_i[BYTE_W-1:0], m.m_raddr_i[BYTE_W-1:0]};

  // ---------------- write channel ----------------
  logic [LEN_W-1:0]  w_cnt, w_len, w_len_cur;
  logic [WORD_W-1:0] w_base, w_base_cur;
  logic              w_idle, w_last, w_xfer;

  // While idle the burst header comes straight from the bus so the first beat
  // goes out with zero latency; it is latched on that first transfer.
  assign w_idle     = (w_cnt == '0);
  assign w_base_cur = w_idle ? m.m_waddr_i[ADDR_W-1:BYTE_W] : w_base;
  assign w_len_cur  = w_idle ? m.m_wlen_i : w_len;
  assign w_last     = (w_cnt == w_len_cur);

  // Combinational outputs are gated with rst_i so they drop immediately on reset.
  assign m.m_wready_o = mem_wready_i & ~rst_i;
  assign m.m_wlast_o  = w_last & ~rst_i;
  assign mem_wen_o    = m.m_wvalid_i & ~rst_i;
  assign mem_waddr_o  = w_base_cur + WORD_W'(w_cnt);
  assign mem_wdata_o  = m.m_wdata_i;
  assign mem_wstrb_o  = m.m_wstrb_i;
  assign w_xfer       = m.m_wvalid_i & m.m_wready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_cnt  <= '0;
      w_len  <= '0;
      w_base <= '0;
    end else if (w_xfer) begin
      if (w_idle) begin
        w_base <= w_base_cur;
        w_len  <= w_len_cur;
      end
      w_cnt <= w_last ? '0 : w_cnt + 1'b1;
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  r_state_t          r_state;
  logic [WORD_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len, r_popped;
  logic [LEN_W:0]    r_issued;        // one extra bit: counts up to len+1
  logic [CNT_W-1:0]  r_outst, f_count;
  logic [PTR_W-1:0]  f_wr, f_rd;
  logic [DATA_W-1:0] f_mem [RD_FIFO_DEPTH];
  logic [CNT_W:0]    r_used;
  logic              r_accept, r_xfer, f_push;

  // Credits cover both queued data and commands still in flight, so every
  // accepted command is guaranteed a FIFO slot when its data returns.
  assign r_used       = {1'b0, f_count} + {1'b0, r_outst};
  assign mem_ren_o    = (r_state == R_BURST) && (r_issued <= {1'b0, r_len}) &&
                        (r_used < (CNT_W+1)'(RD_FIFO_DEPTH));
  assign mem_raddr_o  = r_base + WORD_W'(r_issued);
  assign r_accept     = mem_ren_o & mem_rready_i;
  assign f_push       = mem_rvalid_i;

  assign m.m_rready_o = (f_count != '0);
  assign m.m_rdata_o  = f_mem[f_rd];
  assign m.m_rlast_o  = m.m_rready_o && (r_popped == r_len);
  assign r_xfer       = m.m_rvalid_i & m.m_rready_o;

  always_ff @(posedge clk_i) begin
    if (f_push) f_mem[f_wr] <= mem_rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= R_IDLE;
      r_base   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_popped <= '0;
      r_outst  <= '0;
      f_count  <= '0;
      f_wr     <= '0;
      f_rd     <= '0;
    end else begin
      if (f_push) f_wr <= f_wr + 1'b1;
      if (r_xfer) f_rd <= f_rd + 1'b1;
      f_count <= f_count + CNT_W'(f_push) - CNT_W'(r_xfer);
      r_outst <= r_outst + CNT_W'(r_accept) - CNT_W'(f_push);
      if (r_accept) r_issued <= r_issued + 1'b1;
      case (r_state)
        R_IDLE: begin
          if (m.m_rvalid_i) begin
            r_base   <= m.m_raddr_i[ADDR_W-1:BYTE_W];
            r_len    <= m.m_rlen_i;
            r_issued <= '0;
            r_popped <= '0;
            r_state  <= R_BURST;
          end
        end
        R_BURST: begin
          if (r_xfer) begin
            if (m.m_rlast_o) r_state  <= R_IDLE;
            else             r_popped <= r_popped + 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- completed burst counter ----------------
`ifdef XRESPONDER_BURST_COUNT_EN
  logic w_done, r_done;
  assign w_done = w_xfer & m.m_wlast_o;
  assign r_done = r_xfer & m.m_rlast_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) burst_cnt_o <= '0;
    else       burst_cnt_o <= burst_cnt_o + 32'(w_done) + 32'(r_done);
  end
`else
  assign burst_cnt_o = '0;
`endif
endmodule

// File: tb/tb_xresponder.sv
// tb/tb_xresponder.sv - Scoreboard bench for the xresponder burst responder
module tb_xresponder;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 4;
  localparam int WORD_W = 30;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  xresponder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  logic                mem_wen_o, mem_wready_i;
  logic [WORD_W-1:0]   mem_waddr_o, mem_raddr_o;
  logic [DATA_W-1:0]   mem_wdata_o, mem_rdata_i;
  logic [DATA_W/8-1:0] mem_wstrb_o;
  logic                mem_ren_o, mem_rready_i, mem_rvalid_i;
  logic [31:0]         burst_cnt_o;

  xresponder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m(bus),
    .mem_wen_o(mem_wen_o), .mem_wready_i(mem_wready_i), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ren_o(mem_ren_o), .mem_rready_i(mem_rready_i), .mem_raddr_o(mem_raddr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .burst_cnt_o(burst_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  int exp_bursts = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: fixed 3-cycle read latency, data word = word address.
  logic [2:0]        pv;
  logic [WORD_W-1:0] pa [3];
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pv <= '0;
    else begin
      pv    <= {pv[1:0], mem_ren_o & mem_rready_i};
      pa[0] <= mem_raddr_o;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
    end
  end
  assign mem_rvalid_i = pv[2];
  assign mem_rdata_i  = {2'b00, pa[2]};

  typedef struct packed {
    logic [WORD_W-1:0]   a;
    logic [DATA_W-1:0]   d;
    logic [DATA_W/8-1:0] s;
    logic                l;
  } wbeat_t;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } rbeat_t;
  wbeat_t wq[$];
  rbeat_t rq[$];

  // Write scoreboard
  always @(negedge clk_i) begin
    wbeat_t e;
    if (!rst_i && bus.m_wvalid_i && bus.m_wready_o) begin
      if (wq.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wen", mem_wen_o, 1);
        chk("waddr", mem_waddr_o, e.a);
        chk("wdata", mem_wdata_o, e.d);
        chk("wstrb", mem_wstrb_o, e.s);
        chk("wlast", bus.m_wlast_o, e.l);
      end
    end
  end

  // Read scoreboard
  always @(negedge clk_i) begin
    rbeat_t e;
    if (!rst_i && bus.m_rvalid_i && bus.m_rready_o) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rdata", bus.m_rdata_o, e.d);
        chk("rlast", bus.m_rlast_o, e.l);
      end
    end
  end

  // Independent occupancy model: outstanding commands + queued data.
  int b_out = 0;
  int b_fifo = 0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      b_out  = 0;
      b_fifo = 0;
    end else begin
      chk("credit_bound", (b_out + b_fifo) <= DEPTH, 1);
      chk("rready_vs_model", bus.m_rready_o, b_fifo > 0);
      b_out  = b_out + int'(mem_ren_o && mem_rready_i) - int'(mem_rvalid_i);
      b_fifo = b_fifo + int'(mem_rvalid_i) - int'(bus.m_rvalid_i && bus.m_rready_o);
    end
  end

  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [7:0] stall);
    logic [DATA_W-1:0]   d;
    logic [DATA_W/8-1:0] s;
    logic [WORD_W-1:0]   wa;
    for (int b = 0; b <= len; b++) begin
      d  = $urandom;
      s  = 4'($urandom);
      wa = addr[31:2];
      wa = wa + WORD_W'(b);
      bus.m_wvalid_i = 1'b1;
      bus.m_waddr_i  = addr;
      bus.m_wlen_i   = LEN_W'(len);
      bus.m_wdata_i  = d;
      bus.m_wstrb_i  = s;
      wq.push_back('{a: wa, d: d, s: s, l: (b == len)});
      if (b < 8 && stall[b]) begin
        mem_wready_i = 1'b0;
        @(negedge clk_i);
        chk("wready_stall", bus.m_wready_o, 0);
        chk("wen_stall", mem_wen_o, 1);
        @(posedge clk_i); #1;
        mem_wready_i = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    bus.m_wvalid_i = 1'b0;
    exp_bursts++;
    chk("w_all_beats", wq.size(), 0);
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int len, input int gap);
    logic [WORD_W-1:0] wa;
    int n;
    for (int i = 0; i <= len; i++) begin
      wa = addr[31:2];
      wa = wa + WORD_W'(i);
      rq.push_back('{d: {2'b00, wa}, l: (i == len)});
    end
    bus.m_raddr_i  = addr;
    bus.m_rlen_i   = LEN_W'(len);
    bus.m_rvalid_i = 1'b1;
    @(posedge clk_i); #1;
    if (gap > 0) begin
      bus.m_rvalid_i = 1'b0;
      repeat (gap) @(posedge clk_i);
      @(negedge clk_i);
      chk("fifo_full_rready", bus.m_rready_o, 1);
      chk("fifo_full_level", b_fifo, DEPTH);
      chk("fifo_full_ren_off", mem_ren_o, 0);
      @(posedge clk_i); #1;
      bus.m_rvalid_i = 1'b1;
    end
    n = 0;
    while (rq.size() != 0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("rd_timeout", n < 200, 1);
    bus.m_rvalid_i = 1'b0;
    rq.delete();
    exp_bursts++;
  endtask

  task automatic chk_burst_cnt(input string tag);
`ifdef XRESPONDER_BURST_COUNT_EN
    chk(tag, burst_cnt_o, 32'(exp_bursts));
`else
    chk(tag, burst_cnt_o, 0);
`endif
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wready"}, bus.m_wready_o, 0);
    chk({tag, "_wlast"}, bus.m_wlast_o, 0);
    chk({tag, "_rready"}, bus.m_rready_o, 0);
    chk({tag, "_rlast"}, bus.m_rlast_o, 0);
    chk({tag, "_wen"}, mem_wen_o, 0);
    chk({tag, "_ren"}, mem_ren_o, 0);
    chk({tag, "_bcnt"}, burst_cnt_o, 0);
  endtask

  initial begin
    int n;
    bus.m_wvalid_i = 1'b1;
    bus.m_waddr_i  = '0;
    bus.m_wdata_i  = '0;
    bus.m_wstrb_i  = '0;
    bus.m_wlen_i   = '0;
    bus.m_rvalid_i = 1'b1;
    bus.m_raddr_i  = '0;
    bus.m_rlen_i   = '0;
    mem_wready_i   = 1'b1;
    mem_rready_i   = 1'b1;
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_outputs_zero("reset");
    bus.m_wvalid_i = 1'b0;
    bus.m_rvalid_i = 1'b0;
    rst_i = 1'b0;

    // Writes: 4-beat burst at 0x100, back-to-back 2-beat burst, then backpressure.
    wr_burst(32'h0000_0100, 3, 8'h00);
    wr_burst(32'h0000_0200, 1, 8'h00);
    wr_burst(32'h0000_0300, 3, 8'b0000_0110);

    // Reads: 8-beat burst from 0, then a stalled burst that must fill the FIFO.
    rd_burst(32'h0000_0000, 7, 0);
    rd_burst(32'h0000_0040, 5, 10);
    chk_burst_cnt("burst_cnt_mid");

    // Reset pulse, then len=0 pair at the top word and a wrapping len=1 pair.
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_bursts = 0;
    fork
      wr_burst(32'hFFFF_FFFC, 0, 8'h00);
      rd_burst(32'hFFFF_FFFC, 0, 0);
    join
    chk_burst_cnt("burst_cnt_pair");
    fork
      wr_burst(32'hFFFF_FFFC, 1, 8'h00);
      rd_burst(32'hFFFF_FFFC, 1, 0);
    join
    chk_burst_cnt("burst_cnt_wrap");

    // Reset in the middle of a read burst after three beats are popped.
    for (int i = 0; i < 8; i++) rq.push_back('{d: 32'(i), l: (i == 7)});
    bus.m_raddr_i  = 32'h0;
    bus.m_rlen_i   = 8'd7;
    bus.m_rvalid_i = 1'b1;
    n = 0;
    while (rq.size() > 5 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("rst_mid_timeout", n < 200, 1);
    bus.m_wvalid_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    chk_outputs_zero("rst_mid");
    rq.delete();
    bus.m_wvalid_i = 1'b0;
    bus.m_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_bursts = 0;
    rd_burst(32'h0000_0020, 2, 0);
    chk_burst_cnt("burst_cnt_end");

    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
